imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Parametrised, pipelined immediate generator for the decode stage. It takes one 32-bit RV instruction per cycle over a valid/ready handshake and returns the sign- or zero-extended immediate at XLEN width, together with a format code, an illegal-opcode flag and a pass-through tag such as the PC. It has one register stage and a two-entry skid buffer, so full throughput holds under downstream backpressure, and a flush input supports redirects.

## Interface
- `XLEN`, default 32: immediate width; legal values are 32 and 64.
- `TAG_W`, default 32: width of the opaque tag carried alongside each instruction.
- `CSR_IMM_EN`, default 1: when 1, SYSTEM funct3 101/110/111 yields the zero-extended uimm (zimm); when 0, SYSTEM is format NONE.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `flush` in 1: discard all buffered entries.
- `in_valid` in 1: input instruction valid.
- `in_ready` out 1: block can accept an input this cycle.
- `in_instr` in 32: instruction word.
- `in_tag` in TAG_W: tag, returned unchanged with the result.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_imm` out XLEN: extended immediate.
- `out_fmt` out 3: `imm_fmt_e` (NONE, I, S, B, U, J, CSR).
- `out_illegal` out 1: opcode is not recognised.
- `out_tag` out TAG_W: tag of the result.

## Operation
- Decode rules (on instr[6:0]):
  - I: opcodes 0010011, 0000011, 1100111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - CSR: 1110011, only when funct3[2]=1 and `CSR_IMM_EN`=1.
- Fields per the RV32I base encodings:
  - B and J carry imm[0]=0.
  - U is instr[31:12] followed by 12 zero bits.
- Extension:
  - I, S, B, U and J sign-extend from instr[31] to XLEN; for U at XLEN=64 this means bits 63:32 equal instr[31].
  - CSR zero-extends instr[19:15].
- NONE cases:
  - Opcodes 0110011 and 0001111, and SYSTEM with funct3[2]=0: fmt NONE, imm 0, illegal 0.
  - SYSTEM with funct3[2]=1 and `CSR_IMM_EN`=0: fmt NONE, imm 0, illegal 0.
- Illegal: any other opcode gives fmt NONE, imm 0, illegal 1. Illegal results still flow through the pipe.
- Storage:
  - Main output register (`out_*`) plus one skid register.
  - `in_ready` is the registered value of !skid_valid.
- Accept rule: accept when in_valid && in_ready && !flush.
- Buffer transitions, with fire = out_valid && out_ready:
  - Output empty, or firing, and skid empty: the accepted entry goes to the output register.
  - Output full and not firing: the accepted entry goes to the skid register. in_ready falls the next cycle.
  - Firing with skid full: skid moves to output and skid clears. in_ready rises the next cycle.
  - An input cannot arrive while skid is full, because in_ready=0.
- Order is strictly FIFO; no reordering.
- Flush:
  - Clears out_valid and skid_valid on the edge.
  - Takes priority over accept and over fire.
  - An input presented in the flush cycle is dropped.
  - in_ready=1 the next cycle.
- Reset, with rst_n low at an edge:
  - out_valid=0, out_imm=0, out_fmt=NONE, out_illegal=0, out_tag=0.
  - Skid cleared; in_ready=1.
  - Reset mid-stream drops all entries.
- out_imm, out_fmt, out_illegal and out_tag hold their values while out_valid && !out_ready.

## Timing
- Latency is 1 cycle: an input accepted at edge N is visible at the outputs after edge N, so out_valid is high in cycle N+1.
- Throughput is 1 per cycle with out_ready held high.
- in_ready is registered, with no combinational path from out_ready.
- No combinational path from any input to out_*. Decode is purely combinational in front of the registers.
- Maximum occupancy is 2 entries. in_ready drops one cycle after the skid fills.

## Structure
- Package `imm_pkg` holds:
  - `imm_fmt_e` (3-bit enum: FMT_NONE=0, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_CSR).
  - Opcode localparams (OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL, SYSTEM, OP, MISC_MEM).
- Sub-module `imm_decode`: combinational; takes instr and `XLEN`/`CSR_IMM_EN`, returns imm, fmt and illegal.
- `imm_gen_pipe` holds the handshake, skid buffer and flush logic.
- An elaboration-time assertion enforces XLEN ∈ {32,64}.

## Test plan
- XLEN=32:
  - 0xFFF00093 → imm 0xFFFFFFFF, FMT_I.
  - 0xFE20AE23 → 0xFFFFFFFC, FMT_S.
  - 0xFE000CE3 → 0xFFFFFFF8, FMT_B.
  - 0x0010006F → 0x00000800, FMT_J.
- XLEN=64:
  - 0x123452B7 → 0x0000000012345000, FMT_U.
  - 0x800002B7 → 0xFFFFFFFF80000000, FMT_U.
- CSR and illegal: 0x3002D073 with `CSR_IMM_EN`=1 → 0x5, FMT_CSR. Same input with `CSR_IMM_EN`=0 → FMT_NONE. 0x00000000 → out_illegal=1, imm 0.
- Backpressure:
  - Stimulus: stream 6 tagged instructions with out_ready=0 for 3 cycles.
  - Required: in_ready=0 after 2 accepts, no loss or duplication, output order equals input order, held outputs stable.
- Flush: buffer full, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears.
- Reset: mid-stream rst_n=0 for one cycle → all outputs at reset values; the first post-reset input emerges 1 cycle after acceptance.

Source files
------------

// File: rtl/imm_pkg.sv
// imm_pkg
//   Shared definitions for the immediate generator:
//   - imm_fmt_e : immediate format code returned alongside each result
//   - opcode localparams for the RV32I major opcodes the decoder recognises
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_CSR  = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

endpackage

// File: rtl/imm_decode.sv
// imm_decode
//   Purely combinational immediate decoder for one RV instruction word.
//   Parameters:
//     XLEN       - result width (32 or 64)
//     CSR_IMM_EN - 1: SYSTEM with funct3[2]=1 yields the zero-extended zimm
//   Ports:
//     instr   in  32   instruction word
//     imm     out XLEN extended immediate (0 for NONE / illegal)
//     fmt     out 3    immediate format
//     illegal out 1    opcode not recognised
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit CSR_IMM_EN = 1'b1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic [6:0]  opcode;
  logic [31:0] imm32;

  assign opcode = instr[6:0];

  // Only funct3[2] distinguishes the immediate CSR forms; the low funct3
  // bits play no part in immediate selection.
  logic unused_funct3;
  assign unused_funct3 = ^instr[13:12];

  // Every format is first assembled as a 32-bit value that is already
  // sign-extended to 32 bits. The zimm field is built with bit 31 clear,
  // so a single sign-extension to XLEN below also zero-extends it.
  always_comb begin
    imm32   = 32'd0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_IMM, LOAD, JALR: begin
        imm32 = {{20{instr[31]}}, instr[31:20]};
        fmt   = FMT_I;
      end
      STORE: begin
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        fmt   = FMT_S;
      end
      BRANCH: begin
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                 instr[11:8], 1'b0};
        fmt   = FMT_B;
      end
      LUI, AUIPC: begin
        imm32 = {instr[31:12], 12'd0};
        fmt   = FMT_U;
      end
      JAL: begin
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                 instr[30:21], 1'b0};
        fmt   = FMT_J;
      end
      SYSTEM: begin
        // funct3[2]=0 (ECALL/EBREAK/register CSR ops) carries no immediate.
        if (CSR_IMM_EN && instr[14]) begin
          imm32 = {27'd0, instr[19:15]};
          fmt   = FMT_CSR;
        end
      end
      OP, MISC_MEM: begin
        // Legal but immediate-free: keep the NONE defaults.
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Pipelined immediate generator for the decode stage. One instruction per
//   cycle enters over a valid/ready handshake; the decoded immediate, format,
//   illegal flag and an opaque tag leave one cycle later. A main output
//   register plus a single skid register keep full throughput under
//   downstream backpressure while in_ready stays a pure register output.
//   Parameters:
//     XLEN       - immediate width, 32 or 64
//     TAG_W      - width of the pass-through tag
//     CSR_IMM_EN - enable zimm decoding for SYSTEM funct3 1xx
//   Ports:
//     clk         in  1     clock, rising edge
//     rst_n       in  1     synchronous active-low reset
//     flush       in  1     drop every buffered entry and the current input
//     in_valid    in  1     input valid
//     in_ready    out 1     input can be accepted (registered)
//     in_instr    in  32    instruction word
//     in_tag      in  TAG_W tag returned with the result
//     out_valid   out 1     result valid
//     out_ready   in  1     consumer takes the result
//     out_imm     out XLEN  extended immediate
//     out_fmt     out 3     imm_fmt_e format code
//     out_illegal out 1     opcode not recognised
//     out_tag     out TAG_W tag of the result
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 32,
  parameter bit CSR_IMM_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output imm_fmt_e         out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  // One buffered result: everything the consumer sees for an instruction.
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_fmt_e         fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  // ---------------------------------------------------------------------
  // Decode sits entirely in front of the registers, so nothing on the
  // input side reaches out_* combinationally.
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;

  imm_decode #(
    .XLEN       (XLEN),
    .CSR_IMM_EN (CSR_IMM_EN)
  ) u_decode (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  entry_t in_entry;
  always_comb begin
    in_entry.imm     = dec_imm;
    in_entry.fmt     = dec_fmt;
    in_entry.illegal = dec_illegal;
    in_entry.tag     = in_tag;
  end

  // ---------------------------------------------------------------------
  // Buffer state
  // ---------------------------------------------------------------------
  logic   out_valid_reg,  out_valid_next;
  entry_t out_entry_reg,  out_entry_next;
  logic   skid_valid_reg, skid_valid_next;
  entry_t skid_entry_reg, skid_entry_next;
  logic   in_ready_reg,   in_ready_next;

  logic accept;
  logic fire;

  assign accept = in_valid && in_ready_reg && !flush;
  assign fire   = out_valid_reg && out_ready;

  always_comb begin
    out_valid_next  = out_valid_reg;
    out_entry_next  = out_entry_reg;
    skid_valid_next = skid_valid_reg;
    skid_entry_next = skid_entry_reg;

    if (flush) begin
      // Flush beats both accept and fire; payload registers keep their
      // stale contents since the valid bits are what matter.
      out_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
    end else if (fire) begin
      if (skid_valid_reg) begin
        // The skid entry is older than anything at the input, and no
        // input can be accepted while it is full (in_ready_reg is low).
        out_entry_next  = skid_entry_reg;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        out_entry_next = in_entry;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_reg) begin
        out_valid_next = 1'b1;
        out_entry_next = in_entry;
      end else begin
        // Output stalled: park the new result in the skid register.
        skid_valid_next = 1'b1;
        skid_entry_next = in_entry;
      end
    end

    // Registering !skid_valid_next makes in_ready equal to !skid_valid on
    // every cycle without any path from out_ready.
    in_ready_next = !skid_valid_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_entry_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_entry_reg <= '0;
      in_ready_reg   <= 1'b1;
    end else begin
      out_valid_reg  <= out_valid_next;
      out_entry_reg  <= out_entry_next;
      skid_valid_reg <= skid_valid_next;
      skid_entry_reg <= skid_entry_next;
      in_ready_reg   <= in_ready_next;
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign out_imm     = out_entry_reg.imm;
  assign out_fmt     = out_entry_reg.fmt;
  assign out_illegal = out_entry_reg.illegal;
  assign out_tag     = out_entry_reg.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe
//   Drives three imm_gen_pipe instances (XLEN=32/CSR on, XLEN=64/CSR on,
//   XLEN=32/CSR off) from one shared set of inputs. A negedge monitor holds
//   a FIFO model of the buffered instructions and compares every output of
//   every instance against immediates computed from the RV field rules;
//   the scenario tasks add directed checks.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        v0, v1, v2;
  logic        r0, r1, r2;
  logic [31:0] im0, im2;
  logic [63:0] im1;
  logic [2:0]  f0, f1, f2;
  logic        il0, il1, il2;
  logic [31:0] tg0, tg1, tg2;

  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 1'b0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CSR_IMM_EN(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(r0), .in_instr(in_instr), .in_tag(in_tag), .out_valid(v0),
    .out_ready(out_ready), .out_imm(im0), .out_fmt(f0), .out_illegal(il0),
    .out_tag(tg0));

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CSR_IMM_EN(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(r1), .in_instr(in_instr), .in_tag(in_tag), .out_valid(v1),
    .out_ready(out_ready), .out_imm(im1), .out_fmt(f1), .out_illegal(il1),
    .out_tag(tg1));

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CSR_IMM_EN(1'b0)) dutnc (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(r2), .in_instr(in_instr), .in_tag(in_tag), .out_valid(v2),
    .out_ready(out_ready), .out_imm(im2), .out_fmt(f2), .out_illegal(il2),
    .out_tag(tg2));

  // ---------------------------------------------------------------------
  // Reference decode: field values as signed integers, scaled/extended with
  // plain arithmetic to 64 bits; 32-bit instances compare the low half.
  // fmt codes: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR.
  // ---------------------------------------------------------------------
  function automatic void ref_dec(input logic [31:0] ins, input bit csr_en,
                                  output logic [63:0] imm, output int fmt,
                                  output bit ill);
    imm = 64'd0;
    fmt = 0;
    ill = 1'b0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: begin
        imm = 64'($signed(ins[31:20]));
        fmt = 1;
      end
      7'h23: begin
        imm = 64'($signed({ins[31:25], ins[11:7]}));
        fmt = 2;
      end
      7'h63: begin
        imm = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 64'd2;
        fmt = 3;
      end
      7'h37, 7'h17: begin
        imm = 64'($signed(ins[31:12])) * 64'd4096;
        fmt = 4;
      end
      7'h6f: begin
        imm = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 64'd2;
        fmt = 5;
      end
      7'h73: begin
        if (csr_en && ins[14]) begin
          imm = 64'(ins[19:15]);
          fmt = 6;
        end
      end
      7'h33, 7'h0f: begin
      end
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case ($urandom_range(0, 11))
      0:       op = 7'h13;
      1:       op = 7'h03;
      2:       op = 7'h67;
      3:       op = 7'h23;
      4:       op = 7'h63;
      5:       op = 7'h37;
      6:       op = 7'h17;
      7:       op = 7'h6f;
      8:       op = 7'h73;
      9:       op = 7'h33;
      10:      op = 7'h0f;
      default: op = r[6:0];
    endcase
    return {r[31:7], op};
  endfunction

  // ---------------------------------------------------------------------
  // Scoreboard monitor: the model is just the ordered list of accepted,
  // not-yet-consumed instructions (at most two).
  // ---------------------------------------------------------------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] tag;
  } ent_t;

  ent_t        sb[$];
  logic        exp_v, exp_r;
  logic        a_v, a_r, a_il;
  logic [63:0] a_imm, e_imm;
  logic [2:0]  a_f;
  logic [31:0] a_tg;
  int          e_f;
  bit          e_il;

  always @(negedge clk) begin : monitor
    if (mon_en) begin
      exp_v = (sb.size() > 0);
      exp_r = (sb.size() < 2);
      for (int d = 0; d < 3; d++) begin
        case (d)
          0: begin
            a_v = v0; a_r = r0; a_imm = {32'd0, im0}; a_f = f0; a_il = il0; a_tg = tg0;
          end
          1: begin
            a_v = v1; a_r = r1; a_imm = im1; a_f = f1; a_il = il1; a_tg = tg1;
          end
          default: begin
            a_v = v2; a_r = r2; a_imm = {32'd0, im2}; a_f = f2; a_il = il2; a_tg = tg2;
          end
        endcase
        n_total++;
        if (a_v !== exp_v)
          $display("FAIL mon_out_valid dut%0d t=%0t: got %b want %b", d, $time, a_v, exp_v);
        else n_pass++;
        n_total++;
        if (a_r !== exp_r)
          $display("FAIL mon_in_ready dut%0d t=%0t: got %b want %b", d, $time, a_r, exp_r);
        else n_pass++;
        if (exp_v) begin
          ref_dec(sb[0].instr, d != 2, e_imm, e_f, e_il);
          if (d != 1) e_imm = {32'd0, e_imm[31:0]};
          n_total++;
          if (a_imm !== e_imm)
            $display("FAIL mon_imm dut%0d instr=%08h: got %016h want %016h",
                     d, sb[0].instr, a_imm, e_imm);
          else n_pass++;
          n_total++;
          if (a_f !== 3'(e_f))
            $display("FAIL mon_fmt dut%0d instr=%08h: got %0d want %0d",
                     d, sb[0].instr, a_f, e_f);
          else n_pass++;
          n_total++;
          if (a_il !== e_il)
            $display("FAIL mon_illegal dut%0d instr=%08h: got %b want %b",
                     d, sb[0].instr, a_il, e_il);
          else n_pass++;
          n_total++;
          if (a_tg !== sb[0].tag)
            $display("FAIL mon_tag dut%0d: got %08h want %08h", d, a_tg, sb[0].tag);
          else n_pass++;
        end
      end
      if (exp_v && out_ready && rst_n && !flush)
        $display("txn tag=%08h instr=%08h imm64=%016h fmt=%0d ill=%0d",
                 tg1, sb[0].instr, im1, f1, il1);
      if (!rst_n || flush) begin
        sb.delete();
      end else begin
        if (exp_v && out_ready) void'(sb.pop_front());
        if (in_valid && exp_r) sb.push_back('{instr: in_instr, tag: in_tag});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0;
    in_tag = 32'd0; out_ready = 1'b1;
    tick();
    tick();
    mon_en = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);
    n_total++;
    if (v0 !== 1'b0 || v1 !== 1'b0 || v2 !== 1'b0)
      $display("FAIL reset_out_valid: got %b%b%b want 000", v0, v1, v2);
    else n_pass++;
    n_total++;
    if (r0 !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", r0);
    else n_pass++;
    n_total++;
    if (im0 !== 32'd0 || im1 !== 64'd0)
      $display("FAIL reset_imm: got %08h/%016h want 0", im0, im1);
    else n_pass++;
    n_total++;
    if (f0 !== 3'd0 || il0 !== 1'b0 || tg0 !== 32'd0)
      $display("FAIL reset_fields: got fmt %0d ill %b tag %08h want 0/0/0", f0, il0, tg0);
    else n_pass++;
    tick();
  endtask

  // ---------------------------------------------------------------------
  logic [31:0] vec_instr [9] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3,
                                 32'h0010006F, 32'h123452B7, 32'h800002B7,
                                 32'h3002D073, 32'h3002D073, 32'h00000000};
  int          vec_dut   [9] = '{0, 0, 0, 0, 1, 1, 0, 2, 0};
  logic [63:0] vec_imm   [9] = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'hFFFFFFF8,
                                 64'h00000800, 64'h0000000012345000,
                                 64'hFFFFFFFF80000000, 64'h5, 64'h0, 64'h0};
  logic [2:0]  vec_fmt   [9] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd4, 3'd6, 3'd0, 3'd0};
  logic        vec_ill   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic test_vectors();
    logic        g_v, g_il;
    logic [63:0] g_imm;
    logic [2:0]  g_f;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_instr = vec_instr[i]; in_tag = 32'h1000 + i;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      case (vec_dut[i])
        0:       begin g_v = v0; g_imm = {32'd0, im0}; g_f = f0; g_il = il0; end
        1:       begin g_v = v1; g_imm = im1;          g_f = f1; g_il = il1; end
        default: begin g_v = v2; g_imm = {32'd0, im2}; g_f = f2; g_il = il2; end
      endcase
      n_total++;
      if (g_v !== 1'b1) $display("FAIL vec%0d_latency: out_valid %b want 1", i, g_v);
      else n_pass++;
      n_total++;
      if (g_imm !== vec_imm[i])
        $display("FAIL vec%0d_imm instr=%08h: got %016h want %016h", i, vec_instr[i], g_imm, vec_imm[i]);
      else n_pass++;
      n_total++;
      if (g_f !== vec_fmt[i] || g_il !== vec_ill[i])
        $display("FAIL vec%0d_fmt: got fmt %0d ill %b want fmt %0d ill %b",
                 i, g_f, g_il, vec_fmt[i], vec_ill[i]);
      else n_pass++;
      tick();
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_backpressure();
    int sent = 0;
    int got  = 0;
    for (int c = 0; c < 40 && (sent < 6 || got < 6); c++) begin
      in_valid  = (sent < 6);
      in_instr  = rand_instr();
      in_tag    = 32'd100 + sent;
      out_ready = (c >= 3);
      @(negedge clk);
      if (c == 2) begin
        n_total++;
        if (r0 !== 1'b0) $display("FAIL bp_in_ready_low: got %b want 0", r0);
        else n_pass++;
      end
      if (c == 1 || c == 2) begin
        n_total++;
        if (tg0 !== 32'd100) $display("FAIL bp_hold_tag c%0d: got %0d want 100", c, tg0);
        else n_pass++;
      end
      if (v0 && out_ready) begin
        n_total++;
        if (tg0 !== 32'd100 + got)
          $display("FAIL bp_order: got tag %0d want %0d", tg0, 100 + got);
        else n_pass++;
        got++;
      end
      if (in_valid && r0) sent++;
      tick();
    end
    in_valid = 1'b0;
    n_total++;
    if (sent != 6 || got != 6)
      $display("FAIL bp_count: accepted %0d delivered %0d want 6/6", sent, got);
    else n_pass++;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_flush();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_instr = rand_instr(); in_tag = 32'd200 + k;
      tick();
    end
    in_tag = 32'hDEAD; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (v0 !== 1'b0 || v1 !== 1'b0 || v2 !== 1'b0)
      $display("FAIL flush_out_valid: got %b%b%b want 000", v0, v1, v2);
    else n_pass++;
    n_total++;
    if (r0 !== 1'b1) $display("FAIL flush_in_ready: got %b want 1", r0);
    else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      n_total++;
      if (v0 !== 1'b0) $display("FAIL flush_ghost: out_valid %b tag %08h want 0", v0, tg0);
      else n_pass++;
    end
    tick();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_instr = rand_instr(); in_tag = 32'd400 + k;
      tick();
    end
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (v0 !== 1'b0 || v1 !== 1'b0 || v2 !== 1'b0 || r0 !== 1'b1)
      $display("FAIL rst_mid_handshake: valid %b%b%b ready %b want 000/1", v0, v1, v2, r0);
    else n_pass++;
    n_total++;
    if (im1 !== 64'd0 || f0 !== 3'd0 || il0 !== 1'b0 || tg0 !== 32'd0)
      $display("FAIL rst_mid_fields: imm %016h fmt %0d ill %b tag %08h want 0", im1, f0, il0, tg0);
    else n_pass++;
    tick();
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'd500; out_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (v0 !== 1'b0) $display("FAIL rst_mid_early: out_valid %b want 0", v0);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (v0 !== 1'b1 || tg0 !== 32'd500 || im0 !== 32'hFFFFFFFF)
      $display("FAIL rst_mid_first: valid %b tag %0d imm %08h want 1/500/ffffffff", v0, tg0, im0);
    else n_pass++;
    tick();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_tag    = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst_n     = ($urandom_range(0, 149) != 0);
      tick();
    end
    flush = 1'b0; rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_random();
    @(negedge clk);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
